// File: rtl/rf68000_nic_arb.sv
// rf68000_nic_arb: round-robin arbiter sharing one rf68000_nic slave port among N bus masters.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_*_i           per-requester master buses, requester n occupies slice n of each packed vector
//   req_*_o           terminations back to requesters; req_aack_o routed by tag; req_dat_o shared
//   s_*_o / s_*_i     the single NIC slave port
//   gnt_o             registered one-hot grant (zero when no requester owns the port)
module rf68000_nic_arb #(
   parameter int                  N        = 4,
   parameter int                  TMO_BITS = 10,
   parameter logic [TMO_BITS-1:0] TMO      = TMO_BITS'(1000)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req_cyc_i,
   input  logic [N-1:0]    req_stb_i,
   input  logic [N-1:0]    req_we_i,
   input  logic [3*N-1:0]  req_cti_i,
   input  logic [4*N-1:0]  req_sel_i,
   input  logic [3*N-1:0]  req_fc_i,
   input  logic [32*N-1:0] req_adr_i,
   input  logic [32*N-1:0] req_dat_i,
   output logic [N-1:0]    req_ack_o,
   output logic [N-1:0]    req_err_o,
   output logic [N-1:0]    req_rty_o,
   output logic [N-1:0]    req_vpa_o,
   output logic [N-1:0]    req_aack_o,
   output logic [31:0]     req_dat_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [2:0]      s_cti_o,
   output logic [3:0]      s_sel_o,
   output logic [2:0]      s_fc_o,
   output logic [31:0]     s_adr_o,
   output logic [31:0]     s_dat_o,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   input  logic            s_rty_i,
   input  logic            s_vpa_i,
   input  logic            s_aack_i,
   input  logic [3:0]      s_atag_i,
   input  logic [31:0]     s_dat_i,
   output logic [N-1:0]    gnt_o
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE, S_TMO} state_t;
   localparam logic [3:0] NT = 4'(N);
   state_t              r_state;
   logic [N-1:0]        r_gnt;
   logic [1:0]          r_ptr;
   logic [TMO_BITS-1:0] r_cnt;
   logic [TMO_BITS-1:0] w_cnt_n;
   logic [1:0]          w_sel;
   logic                w_any, w_gr, w_hold, w_term;
   logic [3:0]          w_cyc, w_stb, w_we, w_req;
   logic [2:0]          w_cti [4];
   logic [2:0]          w_fc [4];
   logic [3:0]          w_bsel [4];
   logic [31:0]         w_adr [4];
   logic [31:0]         w_dat [4];
   // Requester buses are padded to four slots so the 2-bit pointer can index them directly.
   for (genvar i = 0; i < 4; i++) begin : g_req
      if (i < N) begin : g_on
         assign w_cyc[i]  = req_cyc_i[i];
         assign w_stb[i]  = req_stb_i[i];
         assign w_we[i]   = req_we_i[i];
         assign w_cti[i]  = req_cti_i[3*i +: 3];
         assign w_fc[i]   = req_fc_i[3*i +: 3];
         assign w_bsel[i] = req_sel_i[4*i +: 4];
         assign w_adr[i]  = req_adr_i[32*i +: 32];
         assign w_dat[i]  = req_dat_i[32*i +: 32];
      end else begin : g_off
         assign w_cyc[i]  = 1'b0;
         assign w_stb[i]  = 1'b0;
         assign w_we[i]   = 1'b0;
         assign w_cti[i]  = '0;
         assign w_fc[i]   = '0;
         assign w_bsel[i] = '0;
         assign w_adr[i]  = '0;
         assign w_dat[i]  = '0;
      end
   end
   assign w_req = w_cyc & w_stb;
   // Scan ptr+N down to ptr+1 so the last hit, i.e. the nearest after ptr, wins.
   always_comb begin
      w_sel = r_ptr;
      w_any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (w_req[2'((int'(r_ptr) + k) % N)]) begin
            w_sel = 2'((int'(r_ptr) + k) % N);
            w_any = 1'b1;
         end
      end
   end
   assign w_gr    = r_state == S_GRANT;
   assign w_hold  = w_cyc[r_ptr];
   assign w_term  = s_ack_i | s_err_i | s_rty_i | s_vpa_i;
   assign w_cnt_n = r_cnt + 1'b1;
   assign s_cyc_o = w_gr & w_cyc[r_ptr];
   assign s_stb_o = w_gr & w_stb[r_ptr];
   assign s_we_o  = w_gr & w_we[r_ptr];
   assign s_cti_o = w_gr ? w_cti[r_ptr] : '0;
   assign s_fc_o  = w_gr ? w_fc[r_ptr] : '0;
   assign s_sel_o = w_gr ? w_bsel[r_ptr] : '0;
   assign s_adr_o = w_gr ? w_adr[r_ptr] : '0;
   assign s_dat_o = w_gr ? w_dat[r_ptr] : '0;
   assign req_ack_o = w_gr ? r_gnt & {N{s_ack_i}} : '0;
   assign req_rty_o = w_gr ? r_gnt & {N{s_rty_i}} : '0;
   assign req_vpa_o = w_gr ? r_gnt & {N{s_vpa_i}} : '0;
   // A timed-out owner keeps seeing err for as long as it still holds cyc.
   assign req_err_o = (w_gr ? r_gnt & {N{s_err_i}} : '0) | (r_state == S_TMO ? r_gnt & req_cyc_i : '0);
   assign req_aack_o = (s_aack_i && s_atag_i < NT) ? N'(1) << s_atag_i[1:0] : '0;
   assign req_dat_o  = s_dat_i;
   assign gnt_o      = r_gnt;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_ptr   <= 2'(N - 1);
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_RELEASE: begin
               r_state <= w_any ? S_GRANT : S_IDLE;
               r_gnt   <= w_any ? N'(1) << w_sel : '0;
               r_ptr   <= w_any ? w_sel : r_ptr;
               r_cnt   <= '0;
            end
            S_GRANT: begin
               if (!w_hold) begin
                  r_state <= S_RELEASE;
                  r_gnt   <= '0;
                  r_cnt   <= '0;
               end else if (w_term) begin
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= w_cnt_n;
                  // A termination in the same cycle takes the branch above, so the ack wins.
                  if (w_cnt_n == TMO) r_state <= S_TMO;
               end
            end
            default: begin
               if (!w_hold) begin
                  r_state <= S_RELEASE;
                  r_gnt   <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rf68000_nic_arb.sv
// tb_rf68000_nic_arb: directed vectors, corner-case sequences and a randomized model comparison for rf68000_nic_arb.
module tb_rf68000_nic_arb;
   localparam int N   = 4;
   localparam int TMO = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [3:0]   cyc, stb, we;
   logic [11:0]  cti, fc;
   logic [15:0]  sel;
   logic [127:0] adr, wdat;
   logic [3:0]   ack_o, err_o, rty_o, vpa_o, aack_o, gnt;
   logic [31:0]  rdat, s_adr, s_dato, s_dati;
   logic         s_cyc, s_stb, s_we;
   logic [2:0]   s_cti, s_fc;
   logic [3:0]   s_sel, s_atag;
   logic         s_ack, s_err, s_rty, s_vpa, s_aack;
   int n_chk = 0;
   int n_pass = 0;
   rf68000_nic_arb #(.N(N), .TMO_BITS(10), .TMO(10'd16)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_cyc_i(cyc), .req_stb_i(stb), .req_we_i(we), .req_cti_i(cti), .req_sel_i(sel),
      .req_fc_i(fc), .req_adr_i(adr), .req_dat_i(wdat),
      .req_ack_o(ack_o), .req_err_o(err_o), .req_rty_o(rty_o), .req_vpa_o(vpa_o),
      .req_aack_o(aack_o), .req_dat_o(rdat),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_cti_o(s_cti), .s_sel_o(s_sel),
      .s_fc_o(s_fc), .s_adr_o(s_adr), .s_dat_o(s_dato),
      .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_vpa_i(s_vpa),
      .s_aack_i(s_aack), .s_atag_i(s_atag), .s_dat_i(s_dati), .gnt_o(gnt)
   );
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask
   task automatic idle();
      cyc = '0; stb = '0; we = '0; cti = '0; fc = '0; sel = '0; adr = '0; wdat = '0;
      s_ack = 0; s_err = 0; s_rty = 0; s_vpa = 0; s_aack = 0; s_atag = '0; s_dati = '0;
   endtask
   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   // Reference model: who owns the port, whether it timed out, how long it has been silent.
   int m_own, m_last, m_sil;
   bit m_to;
   task automatic m_reset();
      m_own = -1; m_last = N - 1; m_sil = 0; m_to = 0;
   endtask
   task automatic m_check();
      int o;
      bit act;
      logic [3:0] oh;
      o   = m_own < 0 ? 0 : m_own;
      act = m_own >= 0 && !m_to;
      oh  = m_own >= 0 ? 4'(1 << m_own) : 4'b0;
      chk("rnd_gnt", 64'(gnt), 64'(oh));
      chk("rnd_scyc", 64'(s_cyc), 64'(act && cyc[o]));
      chk("rnd_sstb", 64'(s_stb), 64'(act && stb[o]));
      chk("rnd_sadr", 64'(s_adr), act ? 64'(adr[o*32 +: 32]) : 64'(0));
      chk("rnd_sdat", 64'(s_dato), act ? 64'(wdat[o*32 +: 32]) : 64'(0));
      chk("rnd_sctl", 64'({s_we, s_cti, s_sel, s_fc}),
          act ? 64'({we[o], cti[o*3 +: 3], sel[o*4 +: 4], fc[o*3 +: 3]}) : 64'(0));
      chk("rnd_ack", 64'(ack_o), 64'(act && s_ack ? oh : 4'b0));
      chk("rnd_err", 64'(err_o), 64'((act && s_err ? oh : 4'b0) | (m_own >= 0 && m_to && cyc[o] ? oh : 4'b0)));
      chk("rnd_rty", 64'(rty_o), 64'(act && s_rty ? oh : 4'b0));
      chk("rnd_vpa", 64'(vpa_o), 64'(act && s_vpa ? oh : 4'b0));
      chk("rnd_aack", 64'(aack_o), 64'(s_aack && s_atag < 4 ? 4'(1 << s_atag) : 4'b0));
      chk("rnd_rdat", 64'(rdat), 64'(s_dati));
   endtask
   task automatic m_step();
      if (m_own < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (cyc[c] && stb[c]) begin
               m_own = c; m_last = c; m_sil = 0; m_to = 0;
               break;
            end
         end
      end else if (!cyc[m_own]) begin
         m_own = -1; m_to = 0;
      end else if (!m_to) begin
         if (s_ack || s_err || s_rty || s_vpa) m_sil = 0;
         else begin
            m_sil++;
            if (m_sil == TMO) m_to = 1;
         end
      end
   endtask
   typedef struct {
      logic [3:0]  cyc;
      logic        ack;
      logic [31:0] sd;
      logic [3:0]  e_gnt;
      logic        e_scyc;
      logic [3:0]  e_ack;
      logic [31:0] e_adr;
   } vec_t;
   vec_t tv [8];
   int order [$];
   logic [3:0] prev, drop;
   int hi, zrun;
   bit seen, quiet;
   initial begin
      tv[0] = '{4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0};
      tv[1] = '{4'b0010, 1'b0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0};
      tv[2] = '{4'b0010, 1'b0, 32'h0, 4'b0010, 1'b1, 4'b0000, 32'h40000000};
      tv[3] = '{4'b0010, 1'b0, 32'h0, 4'b0010, 1'b1, 4'b0000, 32'h40000000};
      tv[4] = '{4'b0010, 1'b0, 32'h0, 4'b0010, 1'b1, 4'b0000, 32'h40000000};
      tv[5] = '{4'b0010, 1'b1, 32'h12345678, 4'b0010, 1'b1, 4'b0010, 32'h40000000};
      tv[6] = '{4'b0000, 1'b0, 32'h0, 4'b0010, 1'b0, 4'b0000, 32'h40000000};
      tv[7] = '{4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0};
      idle();
      // Reset state with every requester asking and the NIC shouting terminations.
      cyc = 4'hf; stb = 4'hf; s_ack = 1; s_err = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_scyc", 64'(s_cyc), 64'(0));
      chk("rst_sstb", 64'(s_stb), 64'(0));
      chk("rst_sadr", 64'(s_adr), 64'(0));
      chk("rst_ack", 64'(ack_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));
      // Requester 1 single read.
      do_reset();
      adr[63:32] = 32'h40000000;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         cyc = tv[i].cyc; stb = tv[i].cyc; s_ack = tv[i].ack; s_dati = tv[i].sd;
         #1;
         chk($sformatf("t1_gnt[%0d]", i), 64'(gnt), 64'(tv[i].e_gnt));
         chk($sformatf("t1_scyc[%0d]", i), 64'(s_cyc), 64'(tv[i].e_scyc));
         chk($sformatf("t1_ack[%0d]", i), 64'(ack_o), 64'(tv[i].e_ack));
         chk($sformatf("t1_adr[%0d]", i), 64'(s_adr), 64'(tv[i].e_adr));
         chk($sformatf("t1_rdat[%0d]", i), 64'(rdat), 64'(tv[i].sd));
      end
      // All four requesters, each acked on its third granted cycle, then drops cyc for one cycle.
      do_reset();
      drop = '0; hi = 0; zrun = 0; seen = 0; prev = '0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         @(negedge clk);
         cyc = ~drop; stb = ~drop; s_ack = hi == 2; drop = '0;
         #1;
         if (gnt != 0 && gnt != prev) begin
            for (int b = 0; b < N; b++) if (gnt[b]) order.push_back(b);
            if (seen) chk("rr_gap", 64'(zrun), 64'(1));
            seen = 1;
         end
         if (gnt == 0 && seen) begin
            zrun++;
            chk("rr_gap_scyc", 64'(s_cyc), 64'(0));
         end else zrun = 0;
         prev = gnt;
         hi = s_cyc ? hi + 1 : 0;
         if (s_ack) drop = ack_o;
      end
      chk("rr_count", 64'(order.size()), 64'(5));
      for (int i = 0; i < order.size() && i < 5; i++) chk($sformatf("rr_order[%0d]", i), 64'(order[i]), 64'(i % N));
      // Requester 2 burst holds the grant while everybody else waits.
      do_reset();
      @(negedge clk);
      cyc = 4'b0100; stb = 4'b0100; cti[8:6] = 3'b001;
      #1 chk("bu_idle", 64'(gnt), 64'(0));
      @(negedge clk);
      cyc = 4'hf; stb = 4'hf;
      #1 chk("bu_gnt", 64'(gnt), 64'(4'b0100));
      chk("bu_cti", 64'(s_cti), 64'(3'b001));
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         s_ack = 1;
         #1 chk($sformatf("bu_gnt[%0d]", b), 64'(gnt), 64'(4'b0100));
         chk($sformatf("bu_ack[%0d]", b), 64'(ack_o), 64'(4'b0100));
      end
      @(negedge clk);
      s_ack = 0; cyc = 4'b1011; stb = 4'b1011;
      #1 chk("bu_drop_gnt", 64'(gnt), 64'(4'b0100));
      chk("bu_drop_scyc", 64'(s_cyc), 64'(0));
      @(negedge clk);
      #1 chk("bu_rel", 64'(gnt), 64'(0));
      @(negedge clk);
      #1 chk("bu_next", 64'(gnt), 64'(4'b1000));
      // Requester 3 never answered: forced error after 16 silent grant cycles.
      do_reset();
      @(negedge clk);
      cyc = 4'b1000; stb = 4'b1000;
      #1 chk("to_idle", 64'(gnt), 64'(0));
      @(negedge clk);
      cyc = 4'b1001; stb = 4'b1001;
      #1 chk("to_gnt", 64'(gnt), 64'(4'b1000));
      chk("to_scyc1", 64'(s_cyc), 64'(1));
      repeat (15) begin
         @(negedge clk);
         #1 chk("to_scyc", 64'(s_cyc), 64'(1));
         chk("to_noerr", 64'(err_o), 64'(0));
      end
      repeat (3) begin
         @(negedge clk);
         #1 chk("to_tmo_scyc", 64'(s_cyc), 64'(0));
         chk("to_tmo_err", 64'(err_o), 64'(4'b1000));
      end
      @(negedge clk);
      cyc = 4'b0001; stb = 4'b0001;
      #1 chk("to_drop_err", 64'(err_o), 64'(0));
      @(negedge clk);
      #1 chk("to_rel", 64'(gnt), 64'(0));
      chk("to_rel_scyc", 64'(s_cyc), 64'(0));
      @(negedge clk);
      #1 chk("to_next", 64'(gnt), 64'(4'b0001));
      chk("to_next_scyc", 64'(s_cyc), 64'(1));
      // Async acks route by tag, regardless of who is granted.
      do_reset();
      @(negedge clk);
      cyc = 4'b0001; stb = 4'b0001;
      @(negedge clk);
      s_aack = 1; s_atag = 4'd2;
      #1 chk("aa_gnt", 64'(gnt), 64'(4'b0001));
      chk("aa_tag2", 64'(aack_o), 64'(4'b0100));
      @(negedge clk);
      s_aack = 0;
      #1 chk("aa_off", 64'(aack_o), 64'(0));
      @(negedge clk);
      s_aack = 1; s_atag = 4'd7;
      #1 chk("aa_tag7", 64'(aack_o), 64'(0));
      @(negedge clk);
      s_atag = 4'd3;
      #1 chk("aa_tag3", 64'(aack_o), 64'(4'b1000));
      // Reset mid-grant takes effect without a clock edge.
      do_reset();
      @(negedge clk);
      cyc = 4'b0100; stb = 4'b0100;
      @(negedge clk);
      #1 chk("mr_gnt", 64'(gnt), 64'(4'b0100));
      #2 rst = 1'b1;
      #1 chk("mr_gnt0", 64'(gnt), 64'(0));
      chk("mr_scyc0", 64'(s_cyc), 64'(0));
      cyc = 4'hf; stb = 4'hf;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1 chk("mr_prio", 64'(gnt), 64'(4'b0001));
      // Randomized traffic against the reference model; odd segments keep the NIC quiet to force timeouts.
      do_reset();
      m_reset();
      for (int seg = 0; seg < 4; seg++) begin
         quiet = (seg % 2) == 1;
         repeat (300) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, quiet ? 40 : 5) == 0) cyc[i] = ~cyc[i];
               stb[i] = $urandom_range(0, 3) != 0;
               we[i] = 1'($urandom);
               cti[i*3 +: 3] = 3'($urandom);
               fc[i*3 +: 3] = 3'($urandom);
               sel[i*4 +: 4] = 4'($urandom);
               adr[i*32 +: 32] = $urandom;
               wdat[i*32 +: 32] = $urandom;
            end
            s_ack  = !quiet && $urandom_range(0, 5) == 0;
            s_err  = !quiet && $urandom_range(0, 30) == 0;
            s_rty  = !quiet && $urandom_range(0, 30) == 0;
            s_vpa  = !quiet && $urandom_range(0, 30) == 0;
            s_aack = $urandom_range(0, 3) == 0;
            s_atag = 4'($urandom_range(0, 5));
            s_dati = $urandom;
            #1 m_check();
            @(posedge clk);
            m_step();
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rf68000_nic_arb.md
# rf68000_nic_arb

Round-robin arbiter that shares one rf68000_nic slave port among N local bus masters: CPU core, DMA, cache refill. It grants one requester at a time and forwards that requester's cycle to the NIC. It routes terminations (ack/err/rty/vpa) back to the granted requester, and routes asynchronous acks (aack) by tag. It guarantees the NIC sees a cyc falling edge between cycles and bounds grant hold time with a timeout.

## Interface
Parameters:
- N, 4: number of requesters, 2..4.
- TMO_BITS, 10: width of the grant timeout counter.
- TMO, 10'd1000: cycles without a termination before a forced error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_cyc_i  in  N  per-requester cycle.
- req_stb_i  in  N  per-requester strobe.
- req_we_i  in  N  per-requester write enable.
- req_cti_i  in  3*N  per-requester cycle type.
- req_sel_i  in  4*N  per-requester byte selects.
- req_fc_i  in  3*N  per-requester function code.
- req_adr_i  in  32*N  per-requester address.
- req_dat_i  in  32*N  per-requester write data.
- req_ack_o  out  N  ack to requester.
- req_err_o  out  N  error to requester.
- req_rty_o  out  N  retry to requester.
- req_vpa_o  out  N  vpa to requester.
- req_aack_o  out  N  async ack, one-cycle pulse.
- req_dat_o  out  32  read data, shared by all requesters.
- s_cyc_o  out  1  cycle to NIC slave port.
- s_stb_o  out  1  strobe to NIC slave port.
- s_we_o  out  1  write enable to NIC slave port.
- s_cti_o  out  3  cycle type to NIC slave port.
- s_sel_o  out  4  byte selects to NIC slave port.
- s_fc_o  out  3  function code to NIC slave port.
- s_adr_o  out  32  address to NIC slave port.
- s_dat_o  out  32  write data to NIC slave port.
- s_ack_i  in  1  NIC ack.
- s_err_i  in  1  NIC error.
- s_rty_i  in  1  NIC retry.
- s_vpa_i  in  1  NIC vpa.
- s_aack_i  in  1  NIC async ack.
- s_atag_i  in  4  NIC async-ack tag.
- s_dat_i  in  32  NIC read data.
- gnt_o  out  N  one-hot current grant, registered.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: cycle forwarded.
  - RELEASE: one cycle, s_cyc_o=0.
  - TMO: forced error.
- Request condition: a requester is requesting when req_cyc_i[n] & req_stb_i[n].
- IDLE, and in RELEASE:
  - If any requester is requesting, load gnt with the first requester found searching from ptr+1 modulo N, ascending.
  - Set ptr to that index and go to GRANT.
  - Otherwise go to or stay in IDLE.
- GRANT, with g the granted index:
  - s_* outputs = requester g's signals.
  - s_cyc_o = req_cyc_i[g]; s_stb_o = req_stb_i[g].
  - Terminations pass combinationally: req_ack_o[g]=s_ack_i, likewise err/rty/vpa; all other requesters see 0.
- Leaving GRANT:
  - When req_cyc_i[g] drops, go to RELEASE and clear gnt.
  - A burst (cti 001/111) holds the grant until cyc drops.
- s_* outputs when not in GRANT: all 0.
- req_dat_o = s_dat_i always.
- Async acks:
  - req_aack_o[s_atag_i[1:0]] = s_aack_i in any state, independent of grant.
  - Tags >= N are dropped.
  - Async acks route by tag to the issuer, not to the current grantee.
- Timeout counter:
  - Clears on entry to GRANT and on any s_ack_i/s_err_i/s_rty_i/s_vpa_i.
  - Increments every GRANT cycle otherwise.
  - When the count equals TMO, go to TMO.
- TMO:
  - s_cyc_o=0.
  - req_err_o[g]=1 until req_cyc_i[g] drops, then RELEASE.
- Reset mid-cycle: all state clears immediately; s_cyc_o drops asynchronously.

## Timing
- Reset values:
  - state=IDLE, gnt_o=0, ptr=N-1 (requester 0 wins first), counter=0.
  - All s_* and req_* outputs 0.
- Grant latency: request seen in IDLE at cycle t gives gnt_o and s_cyc_o high at t+1.
- Termination latency: 0 cycles, combinational pass-through.
- Back-to-back: cyc drop at t gives RELEASE at t+1 (s_cyc_o=0) and next grant at t+2. The minimum 1-cycle s_cyc_o gap is guaranteed.
- Simultaneous events:
  - s_ack_i in the same cycle the count hits TMO: the ack wins and the counter clears.
  - A new request in RELEASE is evaluated, but the grant is not exposed until the next cycle.
  - An aack during GRANT for a different requester is delivered unaffected.
- gnt_o is always one-hot or zero.

## Test plan
- Reset, then requester 1 alone with a read at 0x40000000 and s_ack_i after 3 cycles, s_dat_i=0x12345678 → gnt_o=0010 at t+1; req_ack_o[1] pulses with req_dat_o=0x12345678; s_cyc_o low one cycle after cyc drop.
- All 4 requesters hold cyc continuously, each acked after 2 cycles → grant order 0,1,2,3,0; s_cyc_o low exactly 1 cycle between grants.
- Requester 2 issues a burst with cti=001, 4 beats → grant held across all beats; no other gnt until cyc drops.
- TMO=16, no response to requester 3 → after 16 GRANT cycles s_cyc_o=0 and req_err_o[3]=1 until its cyc drops; then requester 0's pending request is granted.
- During requester 0's grant, s_aack_i=1 with s_atag_i=2 → only req_aack_o[2] pulses, for 1 cycle; tag 7 with N=4 → no aack output.
- rst_i asserted mid-GRANT → gnt_o=0 and s_cyc_o=0 without a clock edge; after release requester 0 has priority.
